// File: rtl/cordic_pkg.sv
// Shared definitions for the CORDIC shift pipeline: mode encodings and the
// per-stage payload layout (shown at the default 32-bit datapath width).
package cordic_pkg;

    localparam logic [1:0] MODE_LSR = 2'b00;
    localparam logic [1:0] MODE_ASR = 2'b01;
    localparam logic [1:0] MODE_LSL = 2'b10;
    localparam logic [1:0] MODE_ROR = 2'b11;

    localparam int CORDIC_N  = 32;
    localparam int CORDIC_AW = $clog2(CORDIC_N);

    typedef struct packed {
        logic [CORDIC_N-1:0]  data;
        logic [CORDIC_AW-1:0] amt;
        logic [1:0]           mode;
        logic                 rbit;
        logic                 valid;
    } shift_stage_t;

endpackage

// File: rtl/cordic_shift_stage.sv
// One barrel-shifter stage: conditionally shifts by 2^K and registers the
// payload, holding it while the downstream stage cannot take it.
module cordic_shift_stage
    import cordic_pkg::*;
#(
    parameter int N  = 32,
    parameter int K  = 0,
    parameter int AW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_data,
    input  logic [AW-1:0] in_amt,
    input  logic [1:0]    in_mode,
    input  logic          in_rbit,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  out_data,
    output logic [AW-1:0] out_amt,
    output logic [1:0]    out_mode,
    output logic          out_rbit
);

    localparam int S = 1 << K;

    logic [N-1:0] shifted;
    logic         rbit_next;
    logic         load;

    // The round bit tracks the last bit pushed out of the bottom of the word.
    always_comb begin
        shifted   = in_data;
        rbit_next = in_rbit;
        if (in_amt[K]) begin
            rbit_next = in_data[S-1];
            case (in_mode)
                MODE_LSR: shifted = {{S{1'b0}}, in_data[N-1:S]};
                MODE_ASR: shifted = {{S{in_data[N-1]}}, in_data[N-1:S]};
                MODE_LSL: shifted = {in_data[N-1-S:0], {S{1'b0}}};
                default:  shifted = {in_data[S-1:0], in_data[N-1:S]};
            endcase
        end
    end

    assign load     = !out_valid || out_ready;
    assign in_ready = load;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_amt   <= '0;
            out_mode  <= '0;
            out_rbit  <= 1'b0;
        end else if (load) begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_data <= shifted;
                out_amt  <= in_amt;
                out_mode <= in_mode;
                out_rbit <= rbit_next;
            end
        end
    end

endmodule

// File: rtl/cordic_shift_pipe.sv
// Pipelined log2(N)-stage barrel shifter (LSR/ASR/LSL/ROR) with valid/ready.
// Define CORDIC_SHIFT_ROUND_EN for round-half-up right shifts (one extra cycle).
module cordic_shift_pipe
    import cordic_pkg::*;
#(
    parameter int N  = 32,
    parameter int AW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_data,
    input  logic [AW-1:0] in_amt,
    input  logic [1:0]    in_mode,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  out_data
);

    logic          valid_c      [0:AW];
    logic [N-1:0]  data_c       [0:AW];
    logic [AW-1:0] amt_c        [0:AW];
    logic [1:0]    mode_c       [0:AW];
    logic          rbit_c       [0:AW];
    logic          up_ready_c   [0:AW-1];
    logic          down_ready_c [0:AW-1];
    logic          tail_ready;

    assign valid_c[0] = in_valid;
    assign data_c[0]  = in_data;
    assign amt_c[0]   = in_amt;
    assign mode_c[0]  = in_mode;
    assign rbit_c[0]  = 1'b0;
    assign in_ready   = up_ready_c[0];

    // A stage may advance when any register further down is empty or the tail
    // drains; computed from valid bits so the ready path never feeds itself.
    always_comb begin
        for (int k = 0; k < AW; k++) begin
            down_ready_c[k] = tail_ready;
            for (int j = k + 2; j <= AW; j++) begin
                if (!valid_c[j]) begin
                    down_ready_c[k] = 1'b1;
                end
            end
        end
    end

    for (genvar k = 0; k < AW; k++) begin : g_stage
        cordic_shift_stage #(
            .N  (N),
            .K  (k),
            .AW (AW)
        ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (valid_c[k]),
            .in_ready  (up_ready_c[k]),
            .in_data   (data_c[k]),
            .in_amt    (amt_c[k]),
            .in_mode   (mode_c[k]),
            .in_rbit   (rbit_c[k]),
            .out_valid (valid_c[k+1]),
            .out_ready (down_ready_c[k]),
            .out_data  (data_c[k+1]),
            .out_amt   (amt_c[k+1]),
            .out_mode  (mode_c[k+1]),
            .out_rbit  (rbit_c[k+1])
        );
    end

`ifdef CORDIC_SHIFT_ROUND_EN
    logic         round_valid;
    logic [N-1:0] round_data;
    logic         round_inc;

    // amt = 0 never shifts, so its round bit stays 0 and it passes unrounded.
    assign round_inc  = rbit_c[AW] && (mode_c[AW] == MODE_LSR || mode_c[AW] == MODE_ASR);
    assign tail_ready = !round_valid || out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            round_valid <= 1'b0;
            round_data  <= '0;
        end else if (tail_ready) begin
            round_valid <= valid_c[AW];
            if (valid_c[AW]) begin
                round_data <= data_c[AW] + {{(N-1){1'b0}}, round_inc};
            end
        end
    end

    assign out_valid = round_valid;
    assign out_data  = round_data;
`else
    assign tail_ready = out_ready;
    assign out_valid  = valid_c[AW];
    assign out_data   = data_c[AW];
`endif

endmodule

// File: doc/cordic_shift_pipe.md
Name: cordic_shift_pipe

Overview:
- Pipelined, parametrised barrel shifter for the iterative and unrolled CORDIC datapaths; the successor to the single-cycle combinational right shifter.
- Supports four shift modes: logical right, arithmetic right, logical left and rotate right.
- Built as a log2(N)-stage pipeline with valid/ready handshake and per-stage backpressure, so one operand can be accepted every cycle.
- Sits between the CORDIC x/y/z registers and the add/sub stage.

Parameters:
- N, 32: data width in bits; must be a power of 2, N >= 4.
- AW, $clog2(N): shift-amount width and pipeline depth; derived, never overridden.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operand present
- in_ready  output  1  block can accept the operand this cycle
- in_data  input  N  operand; signed when mode = ASR
- in_amt  input  AW  unsigned shift amount, 0..N-1
- in_mode  input  2  00 LSR, 01 ASR, 10 LSL, 11 ROR
- out_valid  output  1  result present
- out_ready  input  1  consumer accepts the result
- out_data  output  N  shifted result

Behaviour:
- Reset: synchronous and active-high.
  - All stage valid bits clear to 0 and all stage data registers clear to 0.
  - Therefore out_valid = 0 and out_data = 0 after reset.
  - in_ready = 1 in the first cycle after rst deasserts.
  - A reset mid-operation discards all in-flight operands; no partial result is emitted.
- Structure: stage k (k = 0..AW-1) shifts by 2^k when the amount bit amt[k] is set, otherwise it passes the data through.
  - Each stage register carries: data, the remaining amount bits, mode and valid.
- Latency: AW cycles from input handshake to out_valid (5 cycles for N = 32). Throughput is 1 per cycle when out_ready is held high.
- Handshake:
  - Input transfer occurs on in_valid && in_ready.
  - Output transfer occurs on out_valid && out_ready.
  - out_data and out_valid are held stable while out_valid && !out_ready.
- Stage advance rule:
  - Stage k loads when stage k is empty, or stage k+1 loads in the same cycle.
  - The last stage counts as draining when out_ready is high.
  - in_ready = stage 0 empty || stage 0 advancing. This is bubble-collapsing: an empty stage never stalls upstream.
- Simultaneous input and output transfers in the same cycle must not drop or duplicate any operand.
- Mode rules:
  - LSR fills with 0 from the MSB.
  - ASR fills with copies of in_data[N-1].
  - LSL fills with 0 from the LSB.
  - ROR wraps the LSBs into the MSBs.
- Boundaries:
  - in_amt = 0 returns in_data unchanged in every mode.
  - in_amt = N-1 with ASR on a negative operand gives all ones; with LSR on a negative operand it gives 1.
  - in_mode and in_amt are sampled only at the input handshake.

Optional Feature:
- Macro: CORDIC_SHIFT_ROUND_EN.
- Defined:
  - Right shifts (LSR/ASR) round half-up: result += the last bit shifted out, i.e. the original bit in_amt-1.
  - Each shifting stage captures the round bit data[2^k-1]; a non-shifting stage keeps the captured round bit unchanged.
  - One extra output register performs the add, so latency becomes AW+1.
  - LSL, ROR and amt = 0 are unrounded.
  - The add cannot overflow for amt >= 1.
- Undefined: right shifts truncate and latency is AW.
- The handshake rules are identical in both builds.

Decomposition:
- Package cordic_pkg holds:
  - mode localparams MODE_LSR = 2'b00, MODE_ASR = 2'b01, MODE_LSL = 2'b10, MODE_ROR = 2'b11;
  - the stage payload struct typedef shift_stage_t (data, amt, mode, rbit, valid).
- One sub-module, cordic_shift_stage: a single 2^k shift plus its register with stall logic. It is parameterised by N and K and instantiated AW times in a generate loop.

Test Plan (N = 32, macro undefined unless stated):
- Reset, then ASR of 32'h8000_0000 by 4 with out_ready = 1 -> out_valid rises exactly 5 cycles later with out_data = 32'hF800_0000; LSR of the same operand -> 32'h0800_0000.
- Back-to-back stream of 8 operands, 1 per cycle, in all 4 modes with random amounts (e.g. ROR 32'h0000_0001 by 1 -> 32'h8000_0000; LSL 32'h0000_00FF by 8 -> 32'h0000_FF00) -> 8 results in order, one per cycle, matching the reference model.
- out_ready held low for 10 cycles mid-stream -> at most 5 operands accepted, then in_ready = 0; out_data held stable; after release, no loss or duplication.
- Random valid/ready toggling over 10,000 operands -> scoreboard matches exactly; in_amt = 0 returns the operand; ASR of 32'hFFFF_FFFE by 31 -> 32'hFFFF_FFFF.
- rst asserted with 3 operands in flight -> next cycle out_valid = 0 and out_data = 0; none of those operands ever appears at the output.
- CORDIC_SHIFT_ROUND_EN defined:
  - ASR 32'h0000_0006 by 2 -> 32'h0000_0002 (with latency 6);
  - ASR 32'h0000_0005 by 2 -> 32'h0000_0001;
  - LSL is unrounded.
